// File: rtl/tensor_desc_loader_if.sv
// Word stream in, table write port out. The loader uses the slave view.
interface tensor_desc_loader_if #(
    parameter int ADDR_W     = 8,
    parameter int ENTRY_BITS = 256,
    parameter int WORD_BITS  = 32
);
    logic                  in_valid;
    logic [WORD_BITS-1:0]  in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ENTRY_BITS-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/tensor_desc_loader.sv
// Assembles WPE stream words into one descriptor and writes it to the
// descriptor table at consecutive (wrapping) indices.
module tensor_desc_loader #(
    parameter int NUM_ENTRIES = 256,
    parameter int ENTRY_BITS  = 256,
    parameter int WORD_BITS   = 32,
    parameter int ADDR_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_idx,
    input  logic [ADDR_W:0]      num_desc,
    input  logic                 abort,
    tensor_desc_loader_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int WPE   = ENTRY_BITS / WORD_BITS;
    localparam int WC_W  = (WPE > 1) ? $clog2(WPE) : 1;
    localparam int NUM_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [NUM_W-1:0]      num_q, num_d;
    logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
    logic [NUM_W-1:0]      desc_cnt_q, desc_cnt_d;
    logic [ENTRY_BITS-1:0] asm_q, asm_d;
    logic                  err_q, err_d;
    logic [ADDR_W:0]       addr_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            word_cnt_q <= '0;
            desc_cnt_q <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            word_cnt_q <= word_cnt_d;
            desc_cnt_q <= desc_cnt_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        word_cnt_d = word_cnt_q;
        desc_cnt_d = desc_cnt_q;
        asm_d      = asm_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_desc > NUM_W'(NUM_ENTRIES)) begin
                        err_d = 1'b1;
                    end else begin
                        base_d     = start_idx;
                        num_d      = num_desc;
                        word_cnt_d = '0;
                        desc_cnt_d = '0;
                        state_d    = (num_desc == '0) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus.in_valid) begin
                    asm_d[word_cnt_q*WORD_BITS +: WORD_BITS] = bus.in_data;
                    if (word_cnt_q == WC_W'(WPE - 1)) begin
                        word_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    desc_cnt_d = desc_cnt_q + 1'b1;
                    state_d    = (desc_cnt_d == num_q) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // desc_cnt stays below NUM_ENTRIES while writing, so one conditional subtract wraps
    assign addr_sum = {1'b0, base_q} + {1'b0, desc_cnt_q[ADDR_W-1:0]};

    assign bus.wr_addr  = (addr_sum >= NUM_W'(NUM_ENTRIES))
                          ? ADDR_W'(addr_sum - NUM_W'(NUM_ENTRIES))
                          : addr_sum[ADDR_W-1:0];
    assign bus.wr_data  = asm_q;
    assign bus.wr_en    = (state_q == S_WRITE) && !abort;
    assign bus.in_ready = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
endmodule

// File: tb/tb_tensor_desc_loader.sv
// Randomised stream bench with a write scoreboard and a table shadow model.
module tb_tensor_desc_loader;
    localparam int NE  = 256;
    localparam int EB  = 256;
    localparam int WB  = 32;
    localparam int AW  = 8;
    localparam int WPE = EB / WB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_idx = '0;
    logic [AW:0]   num_desc = '0;
    logic          busy, done, err;

    tensor_desc_loader_if #(.ADDR_W(AW), .ENTRY_BITS(EB), .WORD_BITS(WB)) bus ();

    tensor_desc_loader #(
        .NUM_ENTRIES(NE),
        .ENTRY_BITS (EB),
        .WORD_BITS  (WB),
        .ADDR_W     (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .start_idx(start_idx),
        .num_desc (num_desc),
        .abort    (abort),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int wr_cnt = 0;

    logic [WB-1:0] stim[$];
    logic [AW-1:0] exp_addr[$];
    logic [EB-1:0] exp_data[$];
    logic [EB-1:0] table_m[NE];
    int            wcount[NE];

    task automatic chk(input string name, input logic [EB-1:0] got, input logic [EB-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every table write is popped from the scoreboard and mirrored into table_m
    initial forever begin
        logic [AW-1:0] a;
        logic [EB-1:0] d;
        @(negedge clk);
        if (rst_n) begin
            if (bus.wr_en) begin
                wr_cnt++;
                table_m[bus.wr_addr] = bus.wr_data;
                wcount[bus.wr_addr]++;
                chk("in_ready_in_write", {255'b0, bus.in_ready}, '0);
                if (exp_addr.size() == 0) begin
                    flag_fail("unexpected_write");
                end else begin
                    a = exp_addr.pop_front();
                    d = exp_data.pop_front();
                    chk("wr_addr", EB'(bus.wr_addr), EB'(a));
                    chk("wr_data", bus.wr_data, d);
                end
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
    end

    // Reference: descriptor k of a job is words [8k..8k+7], word j at bit offset 32j
    task automatic push_job(input int idx, input int n, input int first);
        logic [EB-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = '0;
            for (int j = 0; j < WPE; j++)
                d = d | (EB'(stim[first + k*WPE + j]) << (WB*j));
            exp_addr.push_back(AW'((idx + k) % NE));
            exp_data.push_back(d);
        end
    endtask

    task automatic gen_words(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back($urandom);
    endtask

    task automatic do_start(input int idx, input int n);
        start_idx = AW'(idx);
        num_desc  = (AW+1)'(n);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int count, input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < count && guard < 20*count + 100) begin
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            bus.in_data  = stim[first + i];
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (i < count) flag_fail("feed_timeout");
    endtask

    task automatic wait_done(input int bound, output int dcyc);
        bit got = 0;
        dcyc = -1;
        for (int k = 0; k < bound && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got  = 1;
                dcyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        chk("done_seen", {255'b0, got}, EB'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int dcyc;
        int base_w, base_d, base_e, bad;
        logic [EB-1:0] d;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        foreach (wcount[i]) wcount[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {255'b0, bus.in_ready}, '0);
        chk("rst_wr_en",    {255'b0, bus.wr_en},    '0);
        chk("rst_wr_addr",  EB'(bus.wr_addr),       '0);
        chk("rst_wr_data",  bus.wr_data,            '0);
        chk("rst_busy",     {255'b0, busy},         '0);
        chk("rst_done",     {255'b0, done},         '0);
        chk("rst_err",      {255'b0, err},          '0);
        @(posedge clk);
        #1;

        // Single descriptor, counting words, full rate
        stim.delete();
        for (int i = 0; i < WPE; i++) stim.push_back(WB'(i));
        push_job(5, 1, 0);
        do_start(5, 1);
        chk("busy_cycle1", {255'b0, busy}, EB'(1));
        feed(0, WPE, 0);
        wait_done(40, dcyc);
        chk("single_latency", EB'(dcyc - start_cyc), EB'(10));
        chk("single_drained", EB'(exp_addr.size()), '0);
        @(negedge clk);
        chk("busy_after_done", {255'b0, busy}, '0);
        @(posedge clk);
        #1;

        // Wrap-around of the table index
        gen_words(4*WPE);
        push_job(254, 4, 0);
        do_start(254, 4);
        feed(0, 4*WPE, 0);
        wait_done(40, dcyc);
        for (int k = 0; k < 4; k++) begin
            d = '0;
            for (int j = WPE-1; j >= 0; j--) d = (d << WB) | EB'(stim[k*WPE + j]);
            chk("wrap_readback", table_m[(254 + k) % NE], d);
        end

        // Input stalls (~30% idle cycles)
        gen_words(3*WPE);
        base_d = done_cnt;
        base_w = wr_cnt;
        push_job(20, 3, 0);
        do_start(20, 3);
        feed(0, 3*WPE, 30);
        wait_done(60, dcyc);
        chk("stall_writes", EB'(wr_cnt - base_w), EB'(3));
        chk("stall_done_count", EB'(done_cnt - base_d), EB'(1));
        idle(2);

        // num_desc = 0
        base_w = wr_cnt;
        do_start(7, 0);
        wait_done(5, dcyc);
        chk("zero_latency", EB'(dcyc - start_cyc), EB'(1));
        chk("zero_writes", EB'(wr_cnt - base_w), '0);
        idle(1);

        // num_desc = 256 covers every index once
        gen_words(NE*WPE);
        foreach (wcount[i]) wcount[i] = 0;
        base_w = wr_cnt;
        push_job(100, NE, 0);
        do_start(100, NE);
        feed(0, NE*WPE, 0);
        wait_done(20, dcyc);
        bad = 0;
        foreach (wcount[i]) if (wcount[i] != 1) bad++;
        chk("full_coverage", EB'(bad), '0);
        chk("full_writes", EB'(wr_cnt - base_w), EB'(NE));
        idle(2);

        // num_desc = 257 rejected
        base_w = wr_cnt;
        base_e = err_cnt;
        do_start(3, NE + 1);
        @(negedge clk);
        chk("reject_err", {255'b0, err}, EB'(1));
        chk("reject_busy", {255'b0, busy}, '0);
        @(posedge clk);
        #1;
        idle(3);
        chk("reject_err_count", EB'(err_cnt - base_e), EB'(1));
        chk("reject_writes", EB'(wr_cnt - base_w), '0);

        // Abort after word 3 of descriptor 2
        gen_words(2*WPE);
        base_w = wr_cnt;
        base_d = done_cnt;
        push_job(10, 1, 0);
        do_start(10, 2);
        feed(0, WPE + 4, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        idle(5);
        chk("abort_writes", EB'(wr_cnt - base_w), EB'(1));
        chk("abort_no_done", EB'(done_cnt - base_d), '0);
        chk("abort_idle", {255'b0, busy}, '0);
        gen_words(WPE);
        push_job(11, 1, 0);
        do_start(11, 1);
        feed(0, WPE, 0);
        wait_done(40, dcyc);
        chk("after_abort_drained", EB'(exp_addr.size()), '0);
        idle(1);

        // Asynchronous reset while in WRITE
        gen_words(WPE);
        do_start(40, 1);
        feed(0, WPE, 0);
        chk("pre_reset_wr_en", {255'b0, bus.wr_en}, EB'(1));
        rst_n = 1'b0;
        #1;
        chk("async_wr_en",    {255'b0, bus.wr_en},    '0);
        chk("async_busy",     {255'b0, busy},         '0);
        chk("async_in_ready", {255'b0, bus.in_ready}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        gen_words(WPE);
        push_job(41, 1, 0);
        do_start(41, 1);
        feed(0, WPE, 0);
        wait_done(40, dcyc);

        idle(2);
        chk("all_writes_consumed", EB'(exp_addr.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
